// File: rtl/alu_sequencer_if.sv
// Bus bundle between the instruction source, the alu_sequencer and the 8-bit ALU.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_inst;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] alu_ram;
  logic [DATA_W-1:0] alu_rtn;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              err;

  modport slave (
    input  in_data, in_valid, alu_rtn,
    output in_ready, alu_inst, alu_data, alu_ram, out_data, out_valid, busy, err
  );

  modport master (
    output in_data, in_valid, alu_rtn,
    input  in_ready, alu_inst, alu_data, alu_ram, out_data, out_valid, busy, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: fetch/immediate/exec FSM plus a small scratch RAM.
// Define ALU_SEQ_TRAP_EN to trap illegal opcodes into a HALT state with err raised.
module alu_sequencer #(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus
);

  localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_STR  = 4'd1;
  localparam logic [3:0] OP_OUT  = 4'd2;
  localparam logic [3:0] OP_LDAI = 4'd3;
  localparam logic [3:0] OP_LDBI = 4'd4;
  localparam logic [3:0] OP_LDAR = 4'd5;
  localparam logic [3:0] OP_LDBR = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;

`ifdef ALU_SEQ_TRAP_EN
  typedef enum logic [1:0] {FETCH, IMM, EXEC, HALT} state_e;
`else
  typedef enum logic [1:0] {FETCH, IMM, EXEC} state_e;
`endif

  state_e              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   alu_data_q, alu_data_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   ram_q [RAM_DEPTH];
  logic [DATA_W-1:0]   ram_rd;
  logic                ram_we;
  logic                in_ready;
  logic [3:0]          alu_inst;
  logic [3:0]          in_op;
  logic [ADDR_W-1:0]   in_addr;

  assign in_op   = bus.in_data[DATA_W-1 -: 4];
  assign in_addr = bus.in_data[ADDR_W-1:0];
  assign ram_rd  = ram_q[addr_q];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      opcode_q    <= '0;
      addr_q      <= '0;
      alu_data_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      alu_data_q  <= alu_data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Write enable comes from state_q, so an async reset during EXEC suppresses the store.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[addr_q] <= bus.alu_rtn;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    alu_data_d  = alu_data_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    in_ready    = 1'b0;
    alu_inst    = 4'd0;
    ram_we      = 1'b0;

    case (state_q)
      FETCH: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          opcode_d = in_op;
          addr_d   = in_addr;
          case (in_op)
            OP_LDAI, OP_LDBI: state_d = IMM;
            OP_STR, OP_OUT, OP_LDAR, OP_LDBR, OP_ADD: state_d = EXEC;
            OP_NOP: state_d = FETCH;
            default: begin
`ifdef ALU_SEQ_TRAP_EN
              err_d   = 1'b1;
              state_d = HALT;
`else
              state_d = FETCH;
`endif
            end
          endcase
        end
      end
      IMM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          alu_data_d = bus.in_data;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (opcode_q >= OP_LDAI && opcode_q <= OP_ADD) begin
          alu_inst = opcode_q;
        end
        if (opcode_q == OP_STR) begin
          ram_we = 1'b1;
        end
        if (opcode_q == OP_OUT) begin
          out_data_d  = ram_rd;
          out_valid_d = 1'b1;
        end
        state_d = FETCH;
      end
`ifdef ALU_SEQ_TRAP_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_inst  = alu_inst;
  assign bus.alu_data  = alu_data_q;
  assign bus.alu_ram   = ram_rd;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != FETCH);
`ifdef ALU_SEQ_TRAP_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
